// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment scan controller:
// glyph table, dark-cathode pattern, blink phase type and slot-length math.
package ssd_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a} glyphs for hex 0-F, decimal point dark.
  localparam logic [7:0] SEG_LUT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {
    BLINK_OFF = 1'b0,
    BLINK_ON  = 1'b1
  } blink_phase_e;

  // Clock cycles each digit is held so the whole frame refreshes at refr_rate Hz.
  function automatic int calc_slot(input int clk_per, input int refr_rate,
                                   input int num_digits);
    longint den;
    longint q;
    den = longint'(clk_per) * longint'(refr_rate) * longint'(num_digits);
    q   = 64'sd1_000_000_000 / den;
    return (q < 1) ? 1 : int'(q);
  endfunction

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ssd_scan_timer.sv
// Slot prescaler and digit index: holds each digit for SLOT cycles and flags
// the cycle on which the scan wraps from the last digit back to digit 0.
module ssd_scan_timer
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SLOT       = 1,
  localparam int IDX_W     = width_of(NUM_DIGITS),
  localparam int SLOT_W    = width_of(SLOT)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] digit_idx,
  output logic             wrap
);

  logic [SLOT_W-1:0] slot_cnt;
  logic              slot_last;
  logic              digit_last;

  assign slot_last  = (slot_cnt == SLOT_W'(SLOT - 1));
  assign digit_last = (digit_idx == IDX_W'(NUM_DIGITS - 1));
  assign wrap       = slot_last && digit_last;

  // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_last) begin
      slot_cnt  <= '0;
      digit_idx <= digit_last ? '0 : digit_idx + IDX_W'(1);
    end else begin
      slot_cnt  <= slot_cnt + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment display controller: tear-free shadowed digit data,
// PWM brightness, per-digit blink and registered active-low anode/cathode drive.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_PER      = 10,
  parameter int REFR_RATE    = 1000,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode,
  output logic                    frame_done
);

  localparam int SLOT    = calc_slot(CLK_PER, REFR_RATE, NUM_DIGITS);
  localparam int IDX_W   = width_of(NUM_DIGITS);
  localparam int BLINK_W = width_of(BLINK_FRAMES);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   blink_en;
  } shadow_t;

  localparam shadow_t SHADOW_RST = '{value: '0, dp: '0, blank: '1, blink_en: '0};

  logic [IDX_W-1:0]    digit_idx;
  logic                wrap;
  shadow_t             in_s, pend, act;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [BLINK_W-1:0]  blink_cnt;
  blink_phase_e        blink_phase;
  logic                lit;
  logic [3:0]          digit_nib;
  logic [NUM_DIGITS-1:0] anode_d;
  logic [7:0]          cathode_d;

  ssd_scan_timer #(.NUM_DIGITS(NUM_DIGITS), .SLOT(SLOT)) u_timer (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .digit_idx (digit_idx),
    .wrap      (wrap)
  );

  assign in_s = {value, dp, blank, blink_en};

  // Display data only changes at the frame boundary so a frame never mixes old and new glyphs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend <= SHADOW_RST;
      act  <= SHADOW_RST;
    end else begin
      if (load) pend <= in_s;
      if (wrap) act  <= load ? in_s : pend;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= BLINK_ON;
    end else begin
      pwm_cnt <= pwm_cnt + BRIGHT_W'(1);
      if (wrap) begin
        if (blink_cnt == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= (blink_phase == BLINK_ON) ? BLINK_OFF : BLINK_ON;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    anode_d   = '1;
    cathode_d = SEG_OFF;
    digit_nib = act.value[{digit_idx, 2'b00} +: 4];
    lit       = (pwm_cnt <= brightness) && !act.blank[digit_idx] &&
                !(act.blink_en[digit_idx] && (blink_phase == BLINK_OFF));
    if (lit) begin
      anode_d   = ~(NUM_DIGITS'(1) << digit_idx);
      cathode_d = {~act.dp[digit_idx], SEG_LUT[digit_nib][6:0]};
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      anode      <= '1;
      cathode    <= SEG_OFF;
      frame_done <= 1'b0;
    end else begin
      anode      <= anode_d;
      cathode    <= cathode_d;
      frame_done <= wrap;
    end
  end

endmodule
